// File: rtl/mips_intc.sv
// mips_intc: memory-mapped interrupt controller feeding CP0 HWInt[5:0].
// Per-source two-flop synchroniser plus a delay flop for rise detection;
// per-source edge/level mode, pending latch with write-1-to-clear, and a
// software mask. Registers (A): 0 MASK, 1 MODE, 2 PEND, 3 STAT (read-only).
// Optional feature macro: INTC_HOLDOFF_EN adds a per-source re-arm holdoff
// counter that drops edges for HOLDOFF cycles after a software clear.
module mips_intc #(
  parameter int N       = 6,
  parameter int HOLDOFF = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] irq_in,
  input  logic [1:0]   A,
  input  logic         we,
  input  logic [31:0]  wd,
  output logic [31:0]  rd,
  output logic [5:0]   hwint
);

  logic [N-1:0] s1_r, s2_r, s3_r;
  logic [N-1:0] mask_r, mode_r, pend_r;
  logic [5:0]   hwint_r;

  logic [N-1:0] rise_s, accept_s;
  logic [N-1:0] mask_nxt_s, mode_nxt_s, pend_nxt_s;
  logic [N-1:0] w1c_s;
  logic [31:0]  pm_ext_s;
  logic [31:0]  stat_s;
  logic         wr_mask_s, wr_mode_s, wr_pend_s;
  logic         unused_s;

  // Lowest set index of v, or 7 when v is all zero.
  function automatic logic [2:0] lowest_idx(input logic [N-1:0] v);
    logic [2:0] idx;
    idx = 3'd7;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  assign rise_s    = s2_r & ~s3_r;
  assign wr_mask_s = we && (A == 2'd0);
  assign wr_mode_s = we && (A == 2'd1);
  assign wr_pend_s = we && (A == 2'd2);
  assign w1c_s     = wr_pend_s ? (wd[N-1:0] & mode_r) : {N{1'b0}};
  assign pm_ext_s  = 32'(pend_r & mask_r);
  assign stat_s    = {(pend_r & mask_r) != {N{1'b0}}, 28'd0, lowest_idx(pend_r & mask_r)};
  assign hwint     = hwint_r;

`ifdef INTC_HOLDOFF_EN
  localparam int CW = $clog2(HOLDOFF + 1);
  logic [CW-1:0] ho_cnt_r [N];
  logic [N-1:0]  ho_load_s;

  assign unused_s = ^{wd[31:N]};

  // Edges are only accepted once the holdoff counter has run out.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      accept_s[i] = (ho_cnt_r[i] == {CW{1'b0}});
    end
  end

  // Holdoff counters: load on a clearing W1C, count down to zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        ho_cnt_r[i] <= {CW{1'b0}};
      end else if (ho_load_s[i]) begin
        ho_cnt_r[i] <= CW'(HOLDOFF);
      end else if (ho_cnt_r[i] != {CW{1'b0}}) begin
        ho_cnt_r[i] <= ho_cnt_r[i] - CW'(1);
      end
    end
  end
`else
  assign unused_s = ^{wd[31:N], 1'(HOLDOFF)};
  assign accept_s = {N{1'b1}};
`endif

  // Next-state for MASK, MODE and PEND, including mode-change corner cases.
  always_comb begin
    mask_nxt_s = mask_r;
    mode_nxt_s = mode_r;
    pend_nxt_s = pend_r;
`ifdef INTC_HOLDOFF_EN
    ho_load_s  = {N{1'b0}};
`endif
    if (wr_mask_s) mask_nxt_s = wd[N-1:0];
    else           mask_nxt_s = mask_r;
    if (wr_mode_s) mode_nxt_s = wd[N-1:0];
    else           mode_nxt_s = mode_r;
    for (int i = 0; i < N; i++) begin
      if (!mode_r[i] && mode_nxt_s[i]) begin
        // level -> edge: start clean, a rise on this edge is lost
        pend_nxt_s[i] = 1'b0;
      end else if (mode_r[i]) begin
        if (rise_s[i] && accept_s[i]) begin
          pend_nxt_s[i] = 1'b1;            // set beats clear
        end else if (w1c_s[i]) begin
          pend_nxt_s[i] = 1'b0;
`ifdef INTC_HOLDOFF_EN
          ho_load_s[i]  = pend_r[i];       // only a real clear re-arms holdoff
`endif
        end else begin
          pend_nxt_s[i] = pend_r[i];
        end
      end else begin
        pend_nxt_s[i] = s2_r[i];           // level source tracks synchronised line
      end
    end
  end

  // Synchronisers, register file and the registered HWInt vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r    <= {N{1'b0}};
      s2_r    <= {N{1'b0}};
      s3_r    <= {N{1'b0}};
      mask_r  <= {N{1'b0}};
      mode_r  <= {N{1'b0}};
      pend_r  <= {N{1'b0}};
      hwint_r <= 6'd0;
    end else begin
      s1_r    <= irq_in;
      s2_r    <= s1_r;
      s3_r    <= s2_r;
      mask_r  <= mask_nxt_s;
      mode_r  <= mode_nxt_s;
      pend_r  <= pend_nxt_s;
      hwint_r <= pm_ext_s[5:0];
    end
  end

  // Combinational read mux.
  always_comb begin
    rd = 32'd0;
    case (A)
      2'd0:    rd = 32'(mask_r);
      2'd1:    rd = 32'(mode_r);
      2'd2:    rd = 32'(pend_r);
      2'd3:    rd = stat_s;
      default: rd = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mips_intc.sv
// Scoreboard bench for mips_intc: a driver issues one bus cycle per clock and
// pushes the expected rd/hwint for that cycle; a monitor pops and compares on
// the falling edge. Expectations come from a timeline-based reference model
// (sample history, clear timestamps) or from hand-derived constants.
module tb_mips_intc;
  localparam int N       = 6;
  localparam int HOLDOFF = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_in;
  logic [1:0]   A;
  logic         we;
  logic [31:0]  wd;
  logic [31:0]  rd;
  logic [5:0]   hwint;

  mips_intc #(.N(N), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .A(A), .we(we),
    .wd(wd), .rd(rd), .hwint(hwint)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [5:0]  hw;
    string       name;
  } item_t;
  item_t sb[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [N-1:0] m_mask, m_mode, m_pend;
  logic [5:0]   m_hw;
  logic [N-1:0] smp1, smp2, smp3;   // irq samples taken 1, 2, 3 edges ago
  int           edge_no = 0;
  int           last_clr [N];

  function automatic logic [31:0] model_rd(input logic [1:0] aa);
    logic [N-1:0] pm;
    int lo;
    pm = m_pend & m_mask;
    lo = 7;
    for (int i = 0; i < N; i++) if (pm[i] && lo == 7) lo = i;
    case (aa)
      2'd0:    return 32'(m_mask);
      2'd1:    return 32'(m_mode);
      2'd2:    return 32'(m_pend);
      default: return {(pm != 0), 28'd0, lo[2:0]};
    endcase
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] irq,
                            input logic [1:0] aa, input logic w, input logic [31:0] d);
    logic [N-1:0] rise, nmode, np;
    logic acc;
    edge_no++;
    if (r) begin
      m_mask = '0; m_mode = '0; m_pend = '0; m_hw = '0;
      smp1 = '0; smp2 = '0; smp3 = '0;
      for (int i = 0; i < N; i++) last_clr[i] = -1000;
    end else begin
      rise  = smp2 & ~smp3;
      nmode = (w && aa == 2'd1) ? d[N-1:0] : m_mode;
      m_hw  = 6'(m_pend & m_mask);
      np    = m_pend;
      for (int i = 0; i < N; i++) begin
`ifdef INTC_HOLDOFF_EN
        acc = (edge_no - last_clr[i]) > HOLDOFF;
`else
        acc = 1'b1;
`endif
        if (!m_mode[i] && nmode[i]) np[i] = 1'b0;
        else if (m_mode[i]) begin
          if (rise[i] && acc) np[i] = 1'b1;
          else if (w && aa == 2'd2 && d[i] && m_pend[i]) begin
            np[i] = 1'b0;
            last_clr[i] = edge_no;
          end
        end else np[i] = smp2[i];
      end
      m_pend = np;
      m_mode = nmode;
      if (w && aa == 2'd0) m_mask = d[N-1:0];
      smp3 = smp2; smp2 = smp1; smp1 = irq;
    end
  endtask

  // kind: 0 = no check, 1 = model, 2 = constant rd (hw constant if chw >= 0)
  task automatic drive(input logic r, input logic [N-1:0] i, input logic [1:0] aa,
                       input logic w, input logic [31:0] d, input int kind,
                       input logic [31:0] crd, input int chw, input string nm);
    item_t it;
    reset = r; irq_in = i; A = aa; we = w; wd = d;
    if (kind != 0) begin
      it.rd   = (kind == 2) ? crd : model_rd(aa);
      it.hw   = (kind == 2 && chw >= 0) ? 6'(chw) : m_hw;
      it.name = nm;
      sb.push_back(it);
    end
    @(posedge clk);
    model_step(r, i, aa, w, d);
    #1;
  endtask

  // Monitor: compare whatever the driver expects for this cycle.
  always @(negedge clk) begin
    item_t it;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      total++;
      if (rd !== it.rd) begin
        bad++;
        $display("FAIL %s rd: got %08h want %08h (A=%0d)", it.name, rd, it.rd, A);
      end
      total++;
      if (hwint !== it.hw) begin
        bad++;
        $display("FAIL %s hwint: got %06b want %06b", it.name, hwint, it.hw);
      end
    end
  end

  initial begin
    logic [N-1:0] ri;
    logic [1:0]   ra;
    logic         rw, rr;
    logic [31:0]  rdat;
    for (int i = 0; i < N; i++) last_clr[i] = -1000;
    m_mask = '0; m_mode = '0; m_pend = '0; m_hw = '0;
    smp1 = '0; smp2 = '0; smp3 = '0;

    // reset and register defaults
    drive(1, 0, 0, 0, 0, 0, 0, 0, "");
    drive(1, 0, 0, 0, 0, 0, 0, 0, "");
    drive(0, 0, 0, 0, 0, 2, 32'h0, 0, "rst_mask");
    drive(0, 0, 1, 0, 0, 2, 32'h0, 0, "rst_mode");
    drive(0, 0, 2, 0, 0, 2, 32'h0, 0, "rst_pend");
    drive(0, 0, 3, 0, 0, 2, 32'h7, 0, "rst_stat");

    // edge mode, source 2 pulse latency
    drive(0, 0, 1, 1, 32'h3F, 1, 0, 0, "wr_mode");
    drive(0, 0, 0, 1, 32'h3F, 1, 0, 0, "wr_mask");
    drive(0, 6'h04, 2, 0, 0, 1, 0, 0, "e0");
    drive(0, 0, 2, 0, 0, 1, 0, 0, "e1");
    drive(0, 0, 2, 0, 0, 2, 32'h0, 0, "pend_before_e2");
    drive(0, 0, 2, 0, 0, 2, 32'h4, 0, "pend_after_e2");
    drive(0, 6'h02, 3, 0, 0, 2, 32'h80000002, 4, "stat_src2");
    drive(0, 0, 2, 0, 0, 1, 0, 0, "wait");
    drive(0, 0, 2, 1, 32'h4, 1, 0, 0, "w1c2_rise1");
    drive(0, 0, 2, 0, 0, 2, 32'h2, 4, "clear2_set1");
    drive(0, 6'h02, 2, 0, 0, 2, 32'h2, 2, "pend1");
    drive(0, 0, 2, 0, 0, 1, 0, 0, "wait");
    drive(0, 0, 2, 1, 32'h2, 1, 0, 0, "w1c1_rise1");
    drive(0, 0, 2, 0, 0, 2, 32'h2, 2, "set_beats_clear");

    // level mode, held line ignores W1C
    drive(0, 0, 1, 1, 32'h0, 1, 0, 0, "mode_level");
    drive(0, 0, 0, 1, 32'h1, 1, 0, 0, "mask1");
    for (int j = 0; j < 10; j++)
      drive(0, 1, 2, (j == 5), 32'h1, (j >= 3) ? 2 : 1, 32'h1, -1, "level_hold");
    drive(0, 0, 2, 0, 0, 2, 32'h1, 1, "level_drop0");
    drive(0, 0, 2, 0, 0, 2, 32'h1, 1, "level_drop1");
    drive(0, 0, 2, 0, 0, 2, 32'h1, 1, "level_drop2");
    drive(0, 0, 2, 0, 0, 2, 32'h0, 1, "level_cleared");
    drive(0, 0, 2, 0, 0, 2, 32'h0, 0, "hw_level_low");

    // masked pending, then unmask
    drive(0, 0, 1, 1, 32'h3F, 1, 0, 0, "mode_edge");
    drive(0, 0, 0, 1, 32'h0, 1, 0, 0, "mask0");
    drive(0, 6'h28, 2, 0, 0, 1, 0, 0, "p0");
    drive(0, 0, 2, 0, 0, 1, 0, 0, "p1");
    drive(0, 0, 2, 0, 0, 1, 0, 0, "p2");
    drive(0, 0, 2, 0, 0, 2, 32'h28, 0, "pend_masked");
    drive(0, 0, 3, 0, 0, 2, 32'h7, 0, "stat_masked");
    drive(0, 0, 0, 1, 32'h20, 1, 0, 0, "mask20");
    drive(0, 0, 3, 0, 0, 2, 32'h80000005, 0, "stat_src5");
    drive(0, 0, 3, 0, 0, 2, 32'h80000005, 32, "hw_after_mask");

    // re-arm after clear
    drive(0, 0, 2, 1, 32'h3F, 1, 0, 0, "clr_all");
    drive(0, 0, 0, 1, 32'h1, 1, 0, 0, "mask1b");
    drive(0, 1, 2, 0, 0, 1, 0, 0, "h0");
    drive(0, 0, 2, 0, 0, 1, 0, 0, "h1");
    drive(0, 0, 2, 0, 0, 1, 0, 0, "h2");
    drive(0, 0, 2, 0, 0, 2, 32'h1, -1, "ho_pend_set");
    drive(0, 0, 2, 1, 32'h1, 1, 0, 0, "clr_t");
    drive(0, 0, 2, 0, 0, 1, 0, 0, "t1");
    drive(0, 0, 2, 0, 0, 1, 0, 0, "t2");
    drive(0, 1, 2, 0, 0, 1, 0, 0, "t3");
    drive(0, 0, 2, 0, 0, 1, 0, 0, "t4");
    drive(0, 0, 2, 0, 0, 1, 0, 0, "t5");
`ifdef INTC_HOLDOFF_EN
    drive(0, 0, 2, 0, 0, 2, 32'h0, -1, "holdoff_early");
`else
    drive(0, 0, 2, 0, 0, 2, 32'h1, -1, "holdoff_early");
`endif
    drive(0, 0, 2, 1, 32'h1, 1, 0, 0, "t7");
    for (int j = 8; j < 12; j++) drive(0, 0, 2, 0, 0, 1, 0, 0, "tw");
    drive(0, 1, 2, 0, 0, 1, 0, 0, "t12");
    drive(0, 0, 2, 0, 0, 1, 0, 0, "t13");
    drive(0, 0, 2, 0, 0, 1, 0, 0, "t14");
    drive(0, 0, 2, 0, 0, 2, 32'h1, -1, "holdoff_late");

    // randomized traffic against the model
    ri = '0;
    for (int c = 0; c < 3000; c++) begin
      ri   = ri ^ (N'($urandom) & N'($urandom) & N'($urandom));
      ra   = 2'($urandom_range(0, 3));
      rw   = ($urandom_range(0, 3) == 0);
      rdat = $urandom;
      rr   = ($urandom_range(0, 299) == 0);
      drive(rr, ri, ra, rw, rdat, 1, 0, 0, "random");
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_intc.md
Name: mips_intc

Overview:
- Memory-mapped interrupt controller between peripheral IRQ lines and the CP0 HWInt[5:0] input.
- Synchronises raw device requests and detects edges or levels per source.
- Latches pending state and applies a software mask, then drives a registered HWInt vector to CP0.
- Accessed by the CPU through the bridge as four word registers, like the timers.

Parameters:
- N, 6, number of interrupt sources (1..6); source i maps to hwint[i].
- HOLDOFF, 8, re-arm holdoff length in cycles; used only with INTC_HOLDOFF_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- irq_in  input  N  raw device request lines, asynchronous to clk
- A  input  2  register select (bridge address bits [3:2])
- we  input  1  write enable from bridge
- wd  input  32  write data
- rd  output  32  read data, combinational from A
- hwint  output  6  registered interrupt vector to CP0 HWInt

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high: on a posedge clk with reset=1, MASK, MODE, PEND, all synchroniser/edge flops, holdoff counters and hwint go to 0.
  - Reset mid-operation discards all pending state; the write on that edge is ignored.
- Input path, per source:
  - Two-flop synchroniser s1→s2, then delay flop s3.
  - rise_i = s2 & ~s3.
- Register map (bits ≥N read 0, writes to them ignored):
  - A=0 MASK, R/W, reset 0.
  - A=1 MODE, R/W; 1=edge, 0=level; reset 0.
  - A=2 PEND:
    - Edge bits: set on rise_i; write-1-to-clear.
    - Level bits: follow s2 each cycle; writes ignored.
  - A=3 STAT, read-only:
    - [31] = |(PEND&MASK).
    - [2:0] = lowest index i with PEND[i]&MASK[i], else 3'd7.
    - Other bits 0.
- Latency:
  - irq_in high before edge E0 → s1 set at E0, s2 at E1, PEND set at E2, hwint at E3.
  - A MASK write at edge Ek affects hwint at Ek+1.
- hwint <= {zero-extend}(PEND & MASK) every cycle; bits ≥N always 0.
- Simultaneous events and boundaries:
  - Set beats clear: rise_i and W1C of bit i on the same edge → PEND[i] stays 1.
  - Rising edge while PEND[i] is already 1: no change, no count; events coalesce.
  - MODE write changing bit i edge→level: PEND[i] takes s2 from the next edge.
  - MODE write changing bit i level→edge: PEND[i] cleared on the write edge, and a rise on that same edge is lost.
  - Level-mode input held high: PEND stays 1 until the line drops; W1C has no effect.
  - A write to A=3 has no effect.
- Reads are combinational. A read of PEND on the same cycle as a set returns the pre-edge value.

Optional Feature:
- Macro: INTC_HOLDOFF_EN.
- Defined:
  - Each edge source has a down-counter, width $clog2(HOLDOFF+1).
  - A W1C that actually clears PEND[i] loads HOLDOFF.
  - The counter decrements each cycle while nonzero.
  - rise_i seen while the counter is nonzero is dropped, not deferred.
  - Set-beats-clear still applies: if the rise and the clear coincide, PEND stays 1 and the counter is not loaded.
  - Level sources and reset are unaffected (reset zeroes the counters).
- Undefined:
  - No counters.
  - Edges are accepted on the cycle after a clear.

Test Plan:
- Reset, then read all registers → MASK=0, MODE=0, PEND=0, STAT=0x00000007, hwint=6'b0.
- MODE=0x3F, MASK=0x3F; pulse irq_in[2] high for 1 cycle before E0 → PEND=0x04 after E2, hwint=6'b000100 after E3, STAT=0x80000002.
- Continuing that scenario: write PEND=0x04 on the same edge that rise_1 occurs → PEND=0x02 (bit 2 cleared, bit 1 set); then issue W1C of bit 1 on the same edge as a new rise_1 → PEND[1] stays 1.
- MODE=0 (level), MASK=0x01; hold irq_in[0] high 10 cycles, writing PEND=0x01 midway → PEND[0] stays 1 throughout; drop the line → PEND[0]=0 three edges later, hwint[0]=0 one edge after that.
- Edge mode, MASK=0x00; pulse sources 3 and 5 → PEND=0x28, hwint=0, STAT=0x00000007; write MASK=0x20 → hwint=6'b100000 next edge, STAT=0x80000005.
- INTC_HOLDOFF_EN, HOLDOFF=8: clear PEND[0] at cycle t; pulse at t+3 → PEND[0] remains 0; pulse at t+12 → PEND[0]=1. Without the macro, the t+3 pulse sets PEND[0].
